// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, shift forward/backward, parallel load,
// with a saturating occupancy counter and a full flag.
// Stage k occupies bits [k*WIDTH +: WIDTH] of the packed stage array.
module shift_reg_universal #(
    parameter int                       WIDTH = 1,
    parameter int                       DEPTH = 8,
    parameter logic [DEPTH*WIDTH-1:0]   INIT  = '0
) (
    input  logic                           CLK,
    input  logic                           RESETN,
    input  logic                           CLR,
    input  logic                           CE,
    input  logic [1:0]                     MODE,
    input  logic [WIDTH-1:0]               SI,
    input  logic [DEPTH*WIDTH-1:0]         PI,
    output logic [WIDTH-1:0]               SO_F,
    output logic [WIDTH-1:0]               SO_B,
    output logic [DEPTH*WIDTH-1:0]         PO,
    output logic [$clog2(DEPTH+1)-1:0]     COUNT,
    output logic                           FULL
);

    localparam int              N       = DEPTH * WIDTH;
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FWD  = 2'b01;
    localparam logic [1:0] MODE_BWD  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [N-1:0]  stage_q, stage_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] count_inc;

    // Occupancy after one more shift; sticks at DEPTH instead of wrapping.
    assign count_inc = (count_q == DEPTH_C) ? count_q : count_q + CW'(1);

    // Next-state selection: CLR beats the clock enable, which gates MODE.
    always_comb begin
        stage_d = stage_q;
        count_d = count_q;
        if (CLR) begin
            stage_d = '0;
            count_d = '0;
        end else if (CE) begin
            case (MODE)
                MODE_FWD: begin
                    stage_d = {stage_q[N-WIDTH-1:0], SI};
                    count_d = count_inc;
                end
                MODE_BWD: begin
                    stage_d = {SI, stage_q[N-1:WIDTH]};
                    count_d = count_inc;
                end
                MODE_LOAD: begin
                    stage_d = PI;
                    count_d = DEPTH_C;
                end
                MODE_HOLD: begin
                    stage_d = stage_q;
                    count_d = count_q;
                end
                default: begin
                    stage_d = stage_q;
                    count_d = count_q;
                end
            endcase
        end
    end

    // State registers; reset reloads the INIT image and abandons any operation.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            stage_q <= INIT;
            count_q <= '0;
        end else begin
            stage_q <= stage_d;
            count_q <= count_d;
        end
    end

    assign SO_F  = stage_q[N-1 -: WIDTH];
    assign SO_B  = stage_q[WIDTH-1:0];
    assign PO    = stage_q;
    assign COUNT = count_q;
    assign FULL  = (count_q == DEPTH_C);

endmodule

// File: tb/tb_shift_reg_universal.sv
// Bench for shift_reg_universal: three instances (8x1 INIT=0, 8x1 INIT=0x81,
// 3x4) share the control inputs; expected states are queued as stimulus is
// applied and compared after the clock edge.
module tb_shift_reg_universal;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, clr, ce;
    logic [1:0]  mode;
    logic        si;
    logic [7:0]  pi;
    logic [3:0]  si4;
    logic [11:0] pi4;

    logic        so_f8, so_b8, so_fi, so_bi;
    logic [7:0]  po8, poi;
    logic [3:0]  cnt8, cnti;
    logic        full8, fulli;
    logic [3:0]  so_f4, so_b4;
    logic [11:0] po4;
    logic [1:0]  cnt4;
    logic        full4;

    shift_reg_universal #(.WIDTH(1), .DEPTH(8), .INIT(8'h00)) u8 (
        .CLK(clk), .RESETN(resetn), .CLR(clr), .CE(ce), .MODE(mode),
        .SI(si), .PI(pi), .SO_F(so_f8), .SO_B(so_b8), .PO(po8),
        .COUNT(cnt8), .FULL(full8));

    shift_reg_universal #(.WIDTH(1), .DEPTH(8), .INIT(8'h81)) ui (
        .CLK(clk), .RESETN(resetn), .CLR(clr), .CE(ce), .MODE(mode),
        .SI(si), .PI(pi), .SO_F(so_fi), .SO_B(so_bi), .PO(poi),
        .COUNT(cnti), .FULL(fulli));

    shift_reg_universal #(.WIDTH(4), .DEPTH(3)) u4 (
        .CLK(clk), .RESETN(resetn), .CLR(clr), .CE(ce), .MODE(mode),
        .SI(si4), .PI(pi4), .SO_F(so_f4), .SO_B(so_b4), .PO(po4),
        .COUNT(cnt4), .FULL(full4));

    typedef struct {
        string       name;
        int          which;
        logic [15:0] po;
        logic [3:0]  cnt;
        logic        full;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_err    = 0;
    logic [20:0] o;

    // Observed {po, count, full} of one instance, zero-padded to a common width.
    function automatic logic [20:0] obs(int which);
        case (which)
            0:       return {8'h00, po8, cnt8, full8};
            1:       return {8'h00, poi, cnti, fulli};
            default: return {4'h0, po4, 2'b00, cnt4, full4};
        endcase
    endfunction

    task automatic push(string n, int w, logic [15:0] p, logic [3:0] c, logic f);
        exp_t x;
        x.name = n; x.which = w; x.po = p; x.cnt = c; x.full = f;
        sb.push_back(x);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; clr = 1'b0; ce = 1'b1; mode = 2'b01;
        si = 1'b1; pi = 8'hFF; si4 = 4'hF; pi4 = 12'hFFF;
        push("reset_u8", 0, 16'h0000, 4'd0, 1'b0);
        push("reset_ui", 1, 16'h0081, 4'd0, 1'b0);
        push("reset_u4", 2, 16'h0000, 4'd0, 1'b0);
        cycle();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.which);
            n_checks++;
            if (o !== {e.po, e.cnt, e.full}) begin
                n_err++;
                $display("FAIL %s: got po=%h cnt=%0d full=%b, expected po=%h cnt=%0d full=%b",
                         e.name, o[20:5], o[4:1], o[0], e.po, e.cnt, e.full);
            end
        end
        n_checks++;
        if ({so_fi, so_bi} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_ui_serial: got so_f/so_b=%b%b, expected 11", so_fi, so_bi);
        end
    endtask

    // Sequence 1,0,1,1,0,0,1,0 held LSB-first in pat; the first bit shifted in
    // ends up in stage 7, so the final image is 8'hB2.
    task automatic test_shift_fwd();
        logic [7:0] pat;
        logic [7:0] exp_po;
        pat = 8'b0100_1101;
        exp_po = 8'h00;
        resetn = 1'b1; clr = 1'b0; ce = 1'b1; mode = 2'b01;
        for (int i = 0; i < 8; i++) begin
            si = pat[i];
            exp_po = {exp_po[6:0], pat[i]};
            push($sformatf("fwd_%0d", i), 0, {8'h00, exp_po}, 4'(i + 1), i == 7);
            cycle();
            e = sb.pop_front();
            o = obs(e.which);
            n_checks++;
            if (o !== {e.po, e.cnt, e.full}) begin
                n_err++;
                $display("FAIL %s: got po=%h cnt=%0d full=%b, expected po=%h cnt=%0d full=%b",
                         e.name, o[20:5], o[4:1], o[0], e.po, e.cnt, e.full);
            end
        end
        n_checks++;
        if (po8 !== 8'hB2) begin
            n_err++;
            $display("FAIL fwd_image: got po=%h, expected b2", po8);
        end
        si = 1'b0;
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (so_f8 !== pat[j]) begin
                n_err++;
                $display("FAIL fwd_emit_%0d: got so_f=%b, expected %b", j, so_f8, pat[j]);
            end
            cycle();
        end
        n_checks++;
        if ({cnt8, full8} !== {4'd8, 1'b1}) begin
            n_err++;
            $display("FAIL fwd_saturate: got cnt=%0d full=%b, expected 8 1", cnt8, full8);
        end
    endtask

    task automatic test_load_back();
        logic [1:0]  m_t [3]  = '{2'b11, 2'b10, 2'b00};
        logic        s_t [3]  = '{1'b0, 1'b0, 1'b1};
        logic [7:0]  p_t [3]  = '{8'hA5, 8'hA5, 8'hA5};
        logic [7:0]  r_t [3]  = '{8'hA5, 8'h52, 8'h52};
        ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mode = m_t[i]; si = s_t[i]; pi = p_t[i];
            push($sformatf("load_back_%0d", i), 0, {8'h00, r_t[i]}, 4'd8, 1'b1);
            cycle();
            e = sb.pop_front();
            o = obs(e.which);
            n_checks++;
            if (o !== {e.po, e.cnt, e.full}) begin
                n_err++;
                $display("FAIL %s: got po=%h cnt=%0d full=%b, expected po=%h cnt=%0d full=%b",
                         e.name, o[20:5], o[4:1], o[0], e.po, e.cnt, e.full);
            end
        end
        n_checks++;
        if (so_b8 !== 1'b0) begin
            n_err++;
            $display("FAIL back_so_b: got so_b=%b, expected 0", so_b8);
        end
    endtask

    task automatic test_ce_gating();
        logic [7:0] exp_po;
        logic [3:0] exp_cnt;
        resetn = 1'b0;
        cycle();
        resetn = 1'b1; clr = 1'b0; mode = 2'b01; si = 1'b1;
        exp_po = 8'h00; exp_cnt = 4'd0;
        for (int i = 0; i < 3; i++) begin
            ce = (i != 1);
            if (ce) begin
                exp_po = {exp_po[6:0], 1'b1};
                exp_cnt = exp_cnt + 4'd1;
            end
            push($sformatf("ce_%0d", i), 0, {8'h00, exp_po}, exp_cnt, 1'b0);
            cycle();
            e = sb.pop_front();
            o = obs(e.which);
            n_checks++;
            if (o !== {e.po, e.cnt, e.full}) begin
                n_err++;
                $display("FAIL %s: got po=%h cnt=%0d full=%b, expected po=%h cnt=%0d full=%b",
                         e.name, o[20:5], o[4:1], o[0], e.po, e.cnt, e.full);
            end
        end
        ce = 1'b0; mode = 2'b11; pi = 8'hFF;
        push("ce_low_load", 0, 16'h0003, 4'd2, 1'b0);
        cycle();
        e = sb.pop_front();
        o = obs(e.which);
        n_checks++;
        if (o !== {e.po, e.cnt, e.full}) begin
            n_err++;
            $display("FAIL %s: got po=%h cnt=%0d full=%b, expected po=%h cnt=%0d full=%b",
                     e.name, o[20:5], o[4:1], o[0], e.po, e.cnt, e.full);
        end
    endtask

    task automatic test_clear();
        ce = 1'b1; mode = 2'b11; pi = 8'hFF; clr = 1'b0;
        push("clr_pre", 0, 16'h00FF, 4'd8, 1'b1);
        cycle();
        clr = 1'b1; pi = 8'h3C;
        push("clr", 0, 16'h0000, 4'd0, 1'b0);
        cycle();
        clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            o = (i == 0) ? 21'h0 : obs(e.which);
            if (i == 1) begin
                n_checks++;
                if (o !== {e.po, e.cnt, e.full}) begin
                    n_err++;
                    $display("FAIL %s: got po=%h cnt=%0d full=%b, expected po=%h cnt=%0d full=%b",
                             e.name, o[20:5], o[4:1], o[0], e.po, e.cnt, e.full);
                end
            end
        end
    endtask

    // Mixed directions, then a reset landing in the middle of shifting.
    task automatic test_back_to_back();
        logic       rn_t [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] m_t  [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
        logic       s_t  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] r_t  [5] = '{8'h01, 8'h02, 8'h81, 8'h40, 8'h00};
        logic [3:0] c_t  [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        ce = 1'b1; clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            resetn = rn_t[i]; mode = m_t[i]; si = s_t[i];
            push($sformatf("mixed_%0d", i), 0, {8'h00, r_t[i]}, c_t[i], 1'b0);
            cycle();
            e = sb.pop_front();
            o = obs(e.which);
            n_checks++;
            if (o !== {e.po, e.cnt, e.full}) begin
                n_err++;
                $display("FAIL %s: got po=%h cnt=%0d full=%b, expected po=%h cnt=%0d full=%b",
                         e.name, o[20:5], o[4:1], o[0], e.po, e.cnt, e.full);
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_init();
        logic [7:0] exp_po;
        logic [3:0] exp_cnt;
        resetn = 1'b0; clr = 1'b1; ce = 1'b1; mode = 2'b11; pi = 8'hFF;
        push("init_reset", 1, 16'h0081, 4'd0, 1'b0);
        cycle();
        resetn = 1'b1; clr = 1'b0; mode = 2'b01; si = 1'b0;
        exp_po = 8'h81; exp_cnt = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (i > 0) begin
                exp_po = {exp_po[6:0], 1'b0};
                if (exp_cnt != 4'd8) exp_cnt = exp_cnt + 4'd1;
                push($sformatf("init_shift_%0d", i), 1, {8'h00, exp_po}, exp_cnt, exp_cnt == 4'd8);
                cycle();
            end
            e = sb.pop_front();
            o = obs(e.which);
            n_checks++;
            if (o !== {e.po, e.cnt, e.full}) begin
                n_err++;
                $display("FAIL %s: got po=%h cnt=%0d full=%b, expected po=%h cnt=%0d full=%b",
                         e.name, o[20:5], o[4:1], o[0], e.po, e.cnt, e.full);
            end
        end
    endtask

    task automatic test_width4();
        resetn = 1'b1; clr = 1'b0; ce = 1'b1;
        mode = 2'b11; pi4 = 12'h321;
        push("w4_load", 2, 16'h0321, 4'd3, 1'b1);
        cycle();
        mode = 2'b01; si4 = 4'hF;
        push("w4_shift", 2, 16'h021F, 4'd3, 1'b1);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) cycle();
            e = sb.pop_front();
            o = obs(e.which);
            n_checks++;
            if (o !== {e.po, e.cnt, e.full}) begin
                n_err++;
                $display("FAIL %s: got po=%h cnt=%0d full=%b, expected po=%h cnt=%0d full=%b",
                         e.name, o[20:5], o[4:1], o[0], e.po, e.cnt, e.full);
            end
        end
        n_checks++;
        if (so_f4 !== 4'h2) begin
            n_err++;
            $display("FAIL w4_so_f: got so_f=%h, expected 2", so_f4);
        end
    endtask

    initial begin
        resetn = 1'b0; clr = 1'b0; ce = 1'b0; mode = 2'b00;
        si = 1'b0; pi = 8'h00; si4 = 4'h0; pi4 = 12'h000;
        test_reset();
        test_shift_fwd();
        test_load_back();
        test_ce_gating();
        test_clear();
        test_back_to_back();
        test_init();
        test_width4();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
